pipe_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage RV32I core; owns the `stallRange` vector and the PC redirect pair (`pcJump`, `pcTarget`) that feed the PC register.
- Merges per-stage stall requests and arbitrates between ID redirects (JAL) and EX redirects (branch/JALR).
- When the PC cannot accept a redirect because IF is stalled, it latches the redirect and issues it later.
- Drives the flush controls for the IF/ID and ID/EX pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/pipe_ctrl_stall_encoder.sv | 26 ++
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline controller.
//   Stall bit indices (PC, IF, ID, EX, MEM, WB), stall/jump levels,
//   default stall/address widths, controller state encoding and a
//   helper that builds a "stall stages 0..k" mask.
package pipe_ctrl_pkg;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic STALL    = 1'b1;
    localparam logic NO_STALL = 1'b0;
    localparam logic JUMP     = 1'b1;
    localparam logic NO_JUMP  = 1'b0;

    localparam int STALL_RANGE_W = 6;
    localparam int ADDR_RANGE_W  = 32;

    typedef enum logic {
        CTRL_IDLE = 1'b0,
        CTRL_HOLD = 1'b1
    } ctrl_state_t;

    // Mask with bits 0..k set: a stalled stage freezes every stage before it.
    function automatic logic [31:0] stall_upto(input int k);
        return (32'd1 << (k + 1)) - 32'd1;
    endfunction
endpackage

// File: rtl/pipe_ctrl_stall_encoder.sv
// pipe_ctrl_stall_encoder: maps per-stage stall requests to the stall vector.
//   rdy_in         global ready; low stalls every stage
//   req_if_in      IF stall request
//   req_id_in      ID stall request
//   req_ex_in      EX stall request
//   req_mem_in     MEM stall request
//   stall_out      per-stage stall, bit k set for every stage up to the
//                  highest requester (MEM > EX > ID > IF)
module pipe_ctrl_stall_encoder
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_W = STALL_RANGE_W
) (
    input  logic               rdy_in,
    input  logic               req_if_in,
    input  logic               req_id_in,
    input  logic               req_ex_in,
    input  logic               req_mem_in,
    output logic [STALL_W-1:0] stall_out
);
    assign stall_out = !rdy_in    ? '1 :
                       req_mem_in ? STALL_W'(stall_upto(STALL_MEM)) :
                       req_ex_in  ? STALL_W'(stall_upto(STALL_EX)) :
                       req_id_in  ? STALL_W'(stall_upto(STALL_ID)) :
                       req_if_in  ? STALL_W'(stall_upto(STALL_IF)) : '0;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage RV32I core.
//   Merges stall requests into stall_out, arbitrates ID (JAL) and EX
//   (branch/JALR) redirects, holds a redirect while the PC is stalled and
//   drives the IF/ID and ID/EX flushes.
//   clk_in / rst_in          clock, asynchronous active-low reset
//   rdy_in                   global ready (low freezes the core)
//   stallReq{IF,ID,EX,MEM}_in per-stage stall requests
//   jumpID_in/targetID_in    ID redirect request and target
//   jumpEX_in/targetEX_in    EX redirect request and target
//   stall_out                per-stage stall vector
//   pcJump_out/pcTarget_out  PC redirect pair
//   flushIFID_out/flushIDEX_out pipeline register flushes
//   Optional macro PIPE_CTRL_PERF_EN adds perfStall_out / perfRedir_out
//   saturating counters of PC-stall cycles and issued redirects.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_RANGE_W,
    parameter int STALL_W = STALL_RANGE_W
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               stallReqIF_in,
    input  logic               stallReqID_in,
    input  logic               stallReqEX_in,
    input  logic               stallReqMEM_in,
    input  logic               jumpID_in,
    input  logic [ADDR_W-1:0]  targetID_in,
    input  logic               jumpEX_in,
    input  logic [ADDR_W-1:0]  targetEX_in,
    output logic [STALL_W-1:0] stall_out,
    output logic               pcJump_out,
    output logic [ADDR_W-1:0]  pcTarget_out,
    output logic               flushIFID_out,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]        perfStall_out,
    output logic [31:0]        perfRedir_out,
`endif
    output logic               flushIDEX_out
);
    ctrl_state_t        r_state;
    ctrl_state_t        w_next;
    logic [ADDR_W-1:0]  r_target;
    logic [ADDR_W-1:0]  w_new_target;
    logic [ADDR_W-1:0]  w_target;
    logic [STALL_W-1:0] w_stall;
    logic               w_ex_v;
    logic               w_id_v;
    logic               w_latch;
    logic               w_jump;
    logic               w_flush_ifid;
    logic               w_flush_idex;

    pipe_ctrl_stall_encoder #(.STALL_W(STALL_W)) u_enc (
        .rdy_in     (rdy_in),
        .req_if_in  (stallReqIF_in),
        .req_id_in  (stallReqID_in),
        .req_ex_in  (stallReqEX_in),
        .req_mem_in (stallReqMEM_in),
        .stall_out  (w_stall)
    );

    // rdy_in low forces all stall bits, so both valids drop with it.
    // ID redirects in HOLD belong to the wrong path and are ignored.
    assign w_ex_v       = jumpEX_in && (w_stall[STALL_EX] == NO_STALL);
    assign w_id_v       = jumpID_in && (w_stall[STALL_ID] == NO_STALL) && (r_state == CTRL_IDLE);
    assign w_new_target = w_ex_v ? targetEX_in : targetID_in;

    always_comb begin
        w_next       = r_state;
        w_latch      = 1'b0;
        w_jump       = NO_JUMP;
        w_target     = r_target;
        w_flush_ifid = 1'b0;
        w_flush_idex = 1'b0;
        if (r_state == CTRL_IDLE) begin
            if (w_ex_v || w_id_v) begin
                w_flush_ifid = 1'b1;
                w_flush_idex = w_ex_v;
                w_latch      = 1'b1;
                if (w_stall[STALL_PC] == NO_STALL) begin
                    w_jump   = JUMP;
                    w_target = w_new_target;
                end else begin
                    w_next = CTRL_HOLD;
                end
            end
        end else begin
            w_flush_ifid = 1'b1;
            w_flush_idex = w_ex_v;
            w_latch      = w_ex_v;
            if (w_stall[STALL_PC] == NO_STALL) begin
                w_jump   = JUMP;
                w_target = w_ex_v ? targetEX_in : r_target;
                w_next   = CTRL_IDLE;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= CTRL_IDLE;
            r_target <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) r_target <= w_new_target;
        end
    end

    // Outputs are forced low while reset is asserted, independent of inputs.
    assign stall_out     = rst_in ? w_stall : '0;
    assign pcJump_out    = rst_in && w_jump;
    assign pcTarget_out  = rst_in ? w_target : '0;
    assign flushIFID_out = rst_in && w_flush_ifid;
    assign flushIDEX_out = rst_in && w_flush_idex;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_redir;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_perf_stall <= '0;
            r_perf_redir <= '0;
        end else begin
            if (rdy_in && w_stall[STALL_PC] && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
            if (w_jump && r_perf_redir != '1) r_perf_redir <= r_perf_redir + 32'd1;
        end
    end

    assign perfStall_out = r_perf_stall;
    assign perfRedir_out = r_perf_redir;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        stallReqIF_in, stallReqID_in, stallReqEX_in, stallReqMEM_in;
    logic        jumpID_in, jumpEX_in;
    logic [31:0] targetID_in, targetEX_in;
    logic [5:0]  stall_out;
    logic        pcJump_out;
    logic [31:0] pcTarget_out;
    logic        flushIFID_out, flushIDEX_out;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perfStall_out, perfRedir_out;
`endif
    int passed = 0;
    int total  = 0;

    pipe_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .stallReqIF_in  (stallReqIF_in),
        .stallReqID_in  (stallReqID_in),
        .stallReqEX_in  (stallReqEX_in),
        .stallReqMEM_in (stallReqMEM_in),
        .jumpID_in      (jumpID_in),
        .targetID_in    (targetID_in),
        .jumpEX_in      (jumpEX_in),
        .targetEX_in    (targetEX_in),
        .stall_out      (stall_out),
        .pcJump_out     (pcJump_out),
        .pcTarget_out   (pcTarget_out),
        .flushIFID_out  (flushIFID_out),
`ifdef PIPE_CTRL_PERF_EN
        .perfStall_out  (perfStall_out),
        .perfRedir_out  (perfRedir_out),
`endif
        .flushIDEX_out  (flushIDEX_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic clear_inputs();
        rdy_in = 1'b1;
        {stallReqIF_in, stallReqID_in, stallReqEX_in, stallReqMEM_in} = 4'b0;
        jumpID_in = 1'b0; jumpEX_in = 1'b0;
        targetID_in = '0; targetEX_in = '0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        clear_inputs();
        @(negedge clk_in); @(negedge clk_in); #1;
        total++; if (stall_out !== 6'b0) $display("FAIL reset_stall: got %b want 000000", stall_out); else passed++;
        total++; if (pcJump_out !== 1'b0) $display("FAIL reset_pcjump: got %b want 0", pcJump_out); else passed++;
        total++; if (pcTarget_out !== 32'h0) $display("FAIL reset_target: got %h want 0", pcTarget_out); else passed++;
        total++; if ({flushIFID_out, flushIDEX_out} !== 2'b00) $display("FAIL reset_flush: got %b want 00", {flushIFID_out, flushIDEX_out}); else passed++;
        @(negedge clk_in); rst_in = 1'b1;
    endtask

    task automatic test_stall_map();
        logic [3:0] req [7] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b1111, 4'b0011};
        logic [5:0] exp [7] = '{6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b000000, 6'b011111, 6'b000111};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_in);
            {stallReqMEM_in, stallReqEX_in, stallReqID_in, stallReqIF_in} = req[i];
            #1;
            total++; if (stall_out !== exp[i]) $display("FAIL stall_map[%0d]: got %b want %b", i, stall_out, exp[i]); else passed++;
        end
        @(negedge clk_in); clear_inputs(); rdy_in = 1'b0; #1;
        total++; if (stall_out !== 6'b111111) $display("FAIL stall_not_ready: got %b want 111111", stall_out); else passed++;
        @(negedge clk_in); clear_inputs();
    endtask

    task automatic test_ex_redirect();
        @(negedge clk_in); jumpEX_in = 1'b1; targetEX_in = 32'h100; #1;
        total++; if (pcJump_out !== 1'b1) $display("FAIL ex_pcjump: got %b want 1", pcJump_out); else passed++;
        total++; if (pcTarget_out !== 32'h100) $display("FAIL ex_target: got %h want 100", pcTarget_out); else passed++;
        total++; if ({flushIFID_out, flushIDEX_out} !== 2'b11) $display("FAIL ex_flush: got %b want 11", {flushIFID_out, flushIDEX_out}); else passed++;
        @(negedge clk_in); clear_inputs(); #1;
        total++; if (pcJump_out !== 1'b0) $display("FAIL ex_after: got %b want 0", pcJump_out); else passed++;
        total++; if (pcTarget_out !== 32'h100) $display("FAIL ex_target_stable: got %h want 100", pcTarget_out); else passed++;
    endtask

    task automatic test_id_redirect();
        @(negedge clk_in); jumpID_in = 1'b1; targetID_in = 32'h44; #1;
        total++; if ({pcJump_out, flushIFID_out, flushIDEX_out} !== 3'b110) $display("FAIL id_ctrl: got %b want 110", {pcJump_out, flushIFID_out, flushIDEX_out}); else passed++;
        total++; if (pcTarget_out !== 32'h44) $display("FAIL id_target: got %h want 44", pcTarget_out); else passed++;
        @(negedge clk_in); clear_inputs();
    endtask

    task automatic test_both();
        @(negedge clk_in); jumpID_in = 1'b1; targetID_in = 32'h40; jumpEX_in = 1'b1; targetEX_in = 32'h80; #1;
        total++; if (pcTarget_out !== 32'h80) $display("FAIL both_target: got %h want 80", pcTarget_out); else passed++;
        total++; if ({pcJump_out, flushIDEX_out} !== 2'b11) $display("FAIL both_ctrl: got %b want 11", {pcJump_out, flushIDEX_out}); else passed++;
        @(negedge clk_in); clear_inputs();
    endtask

    task automatic test_gated();
        @(negedge clk_in); stallReqEX_in = 1'b1; jumpEX_in = 1'b1; targetEX_in = 32'h900; #1;
        total++; if ({pcJump_out, flushIFID_out, flushIDEX_out} !== 3'b000) $display("FAIL ex_gated: got %b want 000", {pcJump_out, flushIFID_out, flushIDEX_out}); else passed++;
        @(negedge clk_in); clear_inputs(); stallReqID_in = 1'b1; jumpID_in = 1'b1; targetID_in = 32'h904; #1;
        total++; if ({pcJump_out, flushIFID_out} !== 2'b00) $display("FAIL id_gated: got %b want 00", {pcJump_out, flushIFID_out}); else passed++;
        @(negedge clk_in); clear_inputs(); #1;
        total++; if (pcJump_out !== 1'b0) $display("FAIL gated_no_hold: got %b want 0", pcJump_out); else passed++;
    endtask

    task automatic test_hold();
        @(negedge clk_in); jumpID_in = 1'b1; targetID_in = 32'h200; stallReqIF_in = 1'b1; #1;
        total++; if ({pcJump_out, flushIFID_out, flushIDEX_out} !== 3'b010) $display("FAIL hold_c1: got %b want 010", {pcJump_out, flushIFID_out, flushIDEX_out}); else passed++;
        @(negedge clk_in); targetID_in = 32'h500; #1;
        total++; if ({pcJump_out, flushIFID_out, flushIDEX_out} !== 3'b010) $display("FAIL hold_c2_id_ignored: got %b want 010", {pcJump_out, flushIFID_out, flushIDEX_out}); else passed++;
        @(negedge clk_in); jumpID_in = 1'b0; #1;
        total++; if ({pcJump_out, flushIFID_out} !== 2'b01) $display("FAIL hold_c3: got %b want 01", {pcJump_out, flushIFID_out}); else passed++;
        @(negedge clk_in); stallReqIF_in = 1'b0; #1;
        total++; if (pcJump_out !== 1'b1) $display("FAIL hold_issue: got %b want 1", pcJump_out); else passed++;
        total++; if (pcTarget_out !== 32'h200) $display("FAIL hold_issue_target: got %h want 200", pcTarget_out); else passed++;
        @(negedge clk_in); #1;
        total++; if ({pcJump_out, flushIFID_out} !== 2'b00) $display("FAIL hold_back_idle: got %b want 00", {pcJump_out, flushIFID_out}); else passed++;
    endtask

    task automatic test_hold_ex();
        @(negedge clk_in); jumpID_in = 1'b1; targetID_in = 32'h200; stallReqIF_in = 1'b1;
        @(negedge clk_in); jumpID_in = 1'b0; jumpEX_in = 1'b1; targetEX_in = 32'h300; #1;
        total++; if ({pcJump_out, flushIFID_out, flushIDEX_out} !== 3'b011) $display("FAIL hold_ex_accept: got %b want 011", {pcJump_out, flushIFID_out, flushIDEX_out}); else passed++;
        @(negedge clk_in); jumpEX_in = 1'b0; stallReqIF_in = 1'b0; #1;
        total++; if ({pcJump_out, pcTarget_out} !== {1'b1, 32'h300}) $display("FAIL hold_ex_issue: got %b/%h want 1/300", pcJump_out, pcTarget_out); else passed++;
        @(negedge clk_in); clear_inputs();
    endtask

    task automatic test_rdy_hold();
        @(negedge clk_in); jumpID_in = 1'b1; targetID_in = 32'h280; stallReqIF_in = 1'b1;
        @(negedge clk_in); clear_inputs(); rdy_in = 1'b0; #1;
        total++; if ({pcJump_out, stall_out} !== {1'b0, 6'b111111}) $display("FAIL rdy_freeze1: got %b/%b want 0/111111", pcJump_out, stall_out); else passed++;
        @(negedge clk_in); #1;
        total++; if (pcJump_out !== 1'b0) $display("FAIL rdy_freeze2: got %b want 0", pcJump_out); else passed++;
        @(negedge clk_in); rdy_in = 1'b1; #1;
        total++; if ({pcJump_out, pcTarget_out} !== {1'b1, 32'h280}) $display("FAIL rdy_resume: got %b/%h want 1/280", pcJump_out, pcTarget_out); else passed++;
        @(negedge clk_in); clear_inputs();
    endtask

    task automatic test_reset_hold();
        @(negedge clk_in); jumpID_in = 1'b1; targetID_in = 32'h200; stallReqIF_in = 1'b1;
        @(negedge clk_in); jumpID_in = 1'b0; #1;
        total++; if (flushIFID_out !== 1'b1) $display("FAIL rst_hold_pre: got %b want 1", flushIFID_out); else passed++;
        #1 rst_in = 1'b0; #1;
        total++; if ({pcJump_out, flushIFID_out, flushIDEX_out} !== 3'b000) $display("FAIL rst_hold_async: got %b want 000", {pcJump_out, flushIFID_out, flushIDEX_out}); else passed++;
        stallReqIF_in = 1'b0;
        @(negedge clk_in); rst_in = 1'b1; #1;
        total++; if ({pcJump_out, flushIFID_out, pcTarget_out} !== {2'b00, 32'h0}) $display("FAIL rst_hold_discard: got %b%b/%h want 00/0", pcJump_out, flushIFID_out, pcTarget_out); else passed++;
        @(negedge clk_in); #1;
        total++; if (pcJump_out !== 1'b0) $display("FAIL rst_hold_later: got %b want 0", pcJump_out); else passed++;
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        rst_in = 1'b0; clear_inputs();
        @(negedge clk_in); rst_in = 1'b1; #1;
        total++; if ({perfStall_out, perfRedir_out} !== 64'h0) $display("FAIL perf_reset: got %h/%h want 0/0", perfStall_out, perfRedir_out); else passed++;
        jumpEX_in = 1'b1; targetEX_in = 32'h100;
        @(negedge clk_in); clear_inputs(); stallReqIF_in = 1'b1;
        @(negedge clk_in); clear_inputs(); rdy_in = 1'b0;
        @(negedge clk_in); clear_inputs(); #1;
        total++; if ({perfStall_out, perfRedir_out} !== {32'd1, 32'd1}) $display("FAIL perf_counts: got %0d/%0d want 1/1", perfStall_out, perfRedir_out); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_stall_map();
        test_ex_redirect();
        test_id_redirect();
        test_both();
        test_gated();
        test_hold();
        test_hold_ex();
        test_rdy_hold();
        test_reset_hold();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
